vga_grid_probe: RTL and testbench
=================================

# vga_grid_probe

Passive receiver for the 640x480 VGA stream the game top level drives out (hsync, vsync, 3-3-2 RGB). It recovers horizontal/vertical position from the sync pulses alone and checks sync timing against the 800x525 raster. It samples the colour of one selectable 8x8 game-grid cell per frame. It sits on the pixel clock beside the display path and serves as the on-chip and bench checker for everything the game renders.

## Interface
Parameters:
- H_TOTAL, 800, pixel clocks per line
- H_SYNC, 96, hsync low width (clocks)
- H_ACTIVE_START, 144, h count of active column 0 (sync + back porch)
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vsync low width (lines)
- V_ACTIVE_START, 35, line count of active row 0
- PIPE_DELAY, 1, clocks by which RGB lags the sync outputs
- LOCK_FRAMES, 2, consecutive clean frames required to lock

Ports:
- pixel_clk  in  1  pixel clock, 25 MHz
- reset_n  in  1  asynchronous active-low reset
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- vgared  in  3  red
- vgagreen  in  3  green
- vgablue  in  2  blue
- probe_x  in  7  grid column to sample, 0..79
- probe_y  in  7  grid row to sample, 0..59
- locked  out  1  timing lock achieved
- line_err  out  1  one-cycle pulse, horizontal timing violation
- frame_err  out  1  one-cycle pulse, vertical timing violation
- frame_done  out  1  one-cycle pulse at each vsync falling edge
- cell_valid  out  1  one-cycle pulse, cell_color updated
- cell_color  out  3  {R,G,B} of probed cell; each bit = OR of that channel's bits

## Operation
- Reset values: all outputs 0; h_cnt, v_cnt, lock counter 0; state SEARCH; hs_q, vs_q = 1.
- hs_q/vs_q hold the previous-cycle sample. Falling edge = prev 1, current 0.
- h_cnt: set to 0 in the cycle hsync is first sampled low, else increments, saturating at 1023.
- v_cnt: at each hsync falling edge, set to 0 if vsync is sampled low and vs_q = 1, else increments, saturating at 1023.
- Horizontal check: at hsync falling edge, h_cnt must equal H_TOTAL-1. At hsync rising edge, h_cnt must equal H_SYNC-1. Otherwise pulse line_err.
- Vertical check: at vsync falling edge, v_cnt must equal V_TOTAL-1. At vsync rising edge (evaluated on the next hsync falling edge), line count since vsync fall must equal V_SYNC. Otherwise pulse frame_err.
- Checks are armed only after the first edge of that signal following reset or re-entry to SEARCH; the first edge never flags.
- State machine:
  - SEARCH -> COUNT on the first vsync falling edge.
  - COUNT: each clean frame increments the lock counter; at LOCK_FRAMES -> LOCKED with locked=1. Any line_err or frame_err clears the counter and stays in COUNT.
  - LOCKED: any error -> SEARCH, locked=0 in the same cycle the error pulses.
- Active position: x = h_cnt - H_ACTIVE_START - PIPE_DELAY, y = v_cnt - V_ACTIVE_START. Active when 0<=x<640 and 0<=y<480.
- Probe: probe_x/probe_y are latched at vsync falling edge and held for the frame. The sample point is x = 8*px+4, y = 8*py+4, and the colour is latched there.
- At the next vsync falling edge: frame_done=1. If locked was 1 throughout the frame and the latched probe is in range (px<80, py<60), then cell_color updates and cell_valid=1. Out-of-range probe: cell_valid stays 0 and cell_color holds.

## Timing
- All outputs registered. Error pulses occur the cycle after the offending edge is sampled.
- frame_done and cell_valid assert together, the cycle after vsync is sampled low at an hsync falling edge.
- Sync loss (no hsync edge): h_cnt saturates. The next edge flags line_err (if armed).
- A reset_n assertion mid-frame clears everything immediately. Recovery needs 1 + LOCK_FRAMES frames.
- Simultaneous line_err and frame_err both pulse. The state transition is taken once.

## Test plan
- Nominal 800x525 stream, reset released before frame 0 -> locked=1 after the frame-2 vsync falling edge; no error pulses over 5 frames.
- Frame with a single green 8x8 block at cell (40,30), probe (40,30) -> next frame_done has cell_valid=1, cell_color=3'b010; probe (41,30) -> 3'b000.
- One line lengthened to 801 clocks while locked -> single line_err pulse, locked falls the same cycle, relock after 2 clean frames.
- vsync low for 3 lines -> frame_err pulse; no cell_valid on that frame boundary.
- probe_x=80 -> frame_done pulses, cell_valid stays 0, cell_color unchanged.
- reset_n pulsed low mid-line while locked -> outputs 0 immediately; no error on the first post-reset edges.

Source files
------------

// File: rtl/vga_grid_probe.sv
// vga_grid_probe
// Passive checker for a VGA stream (hsync/vsync plus 3-3-2 RGB). It rebuilds
// the raster position from the sync edges alone and checks line and frame
// timing against the configured totals. It holds a lock state once enough
// consecutive clean frames are seen. Once per frame it samples the colour at
// the centre of one selectable 8x8 grid cell.
//
// Ports
//   pixel_clk, reset_n        pixel clock, asynchronous active-low reset
//   hsync, vsync              active-low sync inputs
//   vgared/vgagreen/vgablue   3-3-2 colour; lags the syncs by PIPE_DELAY clocks
//   probe_x, probe_y          grid cell to sample; latched at each frame start
//   locked                    timing lock held
//   line_err, frame_err       one-cycle pulses on horizontal / vertical violations
//   frame_done                one-cycle pulse at each frame start
//   cell_valid, cell_color    one-cycle pulse when cell_color ({R,G,B}) updates
module vga_grid_probe #(
  parameter int H_TOTAL        = 800,
  parameter int H_SYNC         = 96,
  parameter int H_ACTIVE_START = 144,
  parameter int V_TOTAL        = 525,
  parameter int V_SYNC         = 2,
  parameter int V_ACTIVE_START = 35,
  parameter int PIPE_DELAY     = 1,
  parameter int LOCK_FRAMES    = 2
) (
  input  logic       pixel_clk,
  input  logic       reset_n,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] vgared,
  input  logic [2:0] vgagreen,
  input  logic [1:0] vgablue,
  input  logic [6:0] probe_x,
  input  logic [6:0] probe_y,
  output logic       locked,
  output logic       line_err,
  output logic       frame_err,
  output logic       frame_done,
  output logic       cell_valid,
  output logic [2:0] cell_color
);

  localparam int CW = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {ST_SEARCH, ST_COUNT, ST_LOCKED} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_lock_cnt, w_lock_cnt_nxt;
  logic            r_hs_q, r_vs_q;
  logic [9:0]      r_h_cnt, r_v_cnt;
  logic            r_h_armed, r_v_armed, r_vrise_pend;
  logic            r_clean, r_lock_thru;
  logic [7:0]      r_rgb;
  logic [6:0]      r_px, r_py;
  logic [2:0]      r_sample;
  logic            r_locked, r_line_err, r_frame_err, r_frame_done, r_cell_valid;
  logic [2:0]      r_cell_color;

  logic            w_hs_fall, w_hs_rise, w_vs_rise, w_frame_edge;
  logic            w_vrise_chk, w_line_err, w_frame_err, w_any_err;
  logic            w_locked_nxt, w_enter_search;
  logic [10:0]     w_x, w_y;
  logic            w_active, w_probe_hit, w_probe_ok;

  assign w_hs_fall    = r_hs_q & ~hsync;
  assign w_hs_rise    = ~r_hs_q & hsync;
  assign w_vs_rise    = ~r_vs_q & vsync;
  // A frame starts only when vsync is first seen low on an hsync falling edge.
  assign w_frame_edge = w_hs_fall & ~vsync & r_vs_q;

  assign w_line_err = r_h_armed &
                      ((w_hs_fall & (r_h_cnt != 10'(H_TOTAL - 1))) |
                       (w_hs_rise & (r_h_cnt != 10'(H_SYNC - 1))));

  // The end of vsync is judged on the line boundary where the rise is seen.
  // It may also be seen on a later boundary. By then v_cnt + 1 lines have
  // passed since the frame start.
  assign w_vrise_chk = w_hs_fall & (r_vrise_pend | (w_vs_rise & r_v_armed));
  assign w_frame_err = (w_frame_edge & r_v_armed & (r_v_cnt != 10'(V_TOTAL - 1))) |
                       (w_vrise_chk & (r_v_cnt != 10'(V_SYNC - 1)));
  assign w_any_err   = w_line_err | w_frame_err;

  // Position of the pixel held in r_rgb. That register and h_cnt both trail
  // the live inputs by one clock, so only the colour pipeline offset remains.
  // Negative results wrap high and fall outside the active window.
  assign w_x         = {1'b0, r_h_cnt} - 11'(H_ACTIVE_START + PIPE_DELAY);
  assign w_y         = {1'b0, r_v_cnt} - 11'(V_ACTIVE_START);
  assign w_active    = (w_x < 11'd640) & (w_y < 11'd480);
  assign w_probe_hit = w_active & (w_x == {1'b0, r_px, 3'b100}) &
                       (w_y == {1'b0, r_py, 3'b100});
  assign w_probe_ok  = (r_px < 7'd80) & (r_py < 7'd60);

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    unique case (r_state)
      ST_SEARCH: begin
        if (w_frame_edge) begin
          w_state_nxt    = ST_COUNT;
          w_lock_cnt_nxt = '0;
        end
      end
      ST_COUNT: begin
        if (w_any_err) begin
          w_lock_cnt_nxt = '0;
        end else if (w_frame_edge && r_clean) begin
          if (r_lock_cnt == CW'(LOCK_FRAMES - 1)) begin
            w_state_nxt    = ST_LOCKED;
            w_lock_cnt_nxt = '0;
          end else begin
            w_lock_cnt_nxt = r_lock_cnt + CW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (w_any_err) w_state_nxt = ST_SEARCH;
      end
      default: w_state_nxt = ST_SEARCH;
    endcase
  end

  assign w_locked_nxt   = (w_state_nxt == ST_LOCKED);
  assign w_enter_search = (r_state != ST_SEARCH) & (w_state_nxt == ST_SEARCH);

  // NOTE: state is written with non-blocking assignments only. Every register
  // then samples pre-edge values, independent of statement order.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_SEARCH;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_q       <= 1'b1;
      r_vs_q       <= 1'b1;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_h_armed    <= 1'b0;
      r_v_armed    <= 1'b0;
      r_vrise_pend <= 1'b0;
      r_clean      <= 1'b0;
      r_lock_thru  <= 1'b0;
      r_rgb        <= '0;
      r_px         <= '0;
      r_py         <= '0;
      r_sample     <= '0;
      r_locked     <= 1'b0;
      r_line_err   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frame_done <= 1'b0;
      r_cell_valid <= 1'b0;
      r_cell_color <= '0;
    end else begin
      r_hs_q <= hsync;
      r_vs_q <= vsync;
      r_rgb  <= {vgared, vgagreen, vgablue};

      if (w_hs_fall)            r_h_cnt <= '0;
      else if (r_h_cnt != '1)   r_h_cnt <= r_h_cnt + 10'd1;

      if (w_hs_fall) begin
        if (!vsync && r_vs_q)   r_v_cnt <= '0;
        else if (r_v_cnt != '1) r_v_cnt <= r_v_cnt + 10'd1;
      end

      // The first edge after reset or loss of lock only arms its check.
      if (w_enter_search)              r_h_armed <= 1'b0;
      else if (w_hs_fall || w_hs_rise) r_h_armed <= 1'b1;

      if (w_enter_search) begin
        r_v_armed    <= 1'b0;
        r_vrise_pend <= 1'b0;
      end else begin
        if (w_frame_edge || w_vs_rise) r_v_armed <= 1'b1;
        if (w_hs_fall)                 r_vrise_pend <= 1'b0;
        else if (w_vs_rise && r_v_armed) r_vrise_pend <= 1'b1;
      end

      if (w_frame_edge)   r_clean <= 1'b1;
      else if (w_any_err) r_clean <= 1'b0;

      if (w_frame_edge)       r_lock_thru <= w_locked_nxt;
      else if (!w_locked_nxt) r_lock_thru <= 1'b0;

      if (w_frame_edge) begin
        r_px <= probe_x;
        r_py <= probe_y;
      end
      if (w_probe_hit) r_sample <= {|r_rgb[7:5], |r_rgb[4:2], |r_rgb[1:0]};

      r_locked     <= w_locked_nxt;
      r_line_err   <= w_line_err;
      r_frame_err  <= w_frame_err;
      r_frame_done <= w_frame_edge;
      r_cell_valid <= w_frame_edge & r_lock_thru & w_locked_nxt & w_probe_ok;
      if (w_frame_edge && r_lock_thru && w_locked_nxt && w_probe_ok)
        r_cell_color <= r_sample;
    end
  end

  assign locked     = r_locked;
  assign line_err   = r_line_err;
  assign frame_err  = r_frame_err;
  assign frame_done = r_frame_done;
  assign cell_valid = r_cell_valid;
  assign cell_color = r_cell_color;

endmodule

// File: tb/tb_vga_grid_probe.sv
// Directed bench for vga_grid_probe on a reduced raster. The raster is 100
// clocks per line and 40 lines per frame. The probe cells lie inside the
// visible part of that raster. A green 8x8 block fills grid cell (4,2).
module tb_vga_grid_probe;

  localparam int HT = 100;
  localparam int HS = 10;
  localparam int HA = 20;
  localparam int VT = 40;
  localparam int VS = 2;
  localparam int VA = 5;
  localparam int PD = 1;

  logic       pixel_clk = 1'b0;
  logic       reset_n;
  logic       hsync, vsync;
  logic [2:0] vgared, vgagreen;
  logic [1:0] vgablue;
  logic [6:0] probe_x, probe_y;
  logic       locked, line_err, frame_err, frame_done, cell_valid;
  logic [2:0] cell_color;

  int n_checks = 0;
  int n_bad    = 0;

  // Event counters kept by the monitor.
  int         n_le = 0, n_fe = 0, n_fd = 0, n_cv = 0;
  logic       last_valid = 1'b0;
  logic [2:0] last_color = 3'b000;
  logic       prev_locked = 1'b0, err_lock_now = 1'b0, err_lock_prev = 1'b0;

  int s_le, s_fe, s_fd;

  vga_grid_probe #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_ACTIVE_START(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_ACTIVE_START(VA),
    .PIPE_DELAY(PD), .LOCK_FRAMES(2)
  ) dut (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .hsync     (hsync),
    .vsync     (vsync),
    .vgared    (vgared),
    .vgagreen  (vgagreen),
    .vgablue   (vgablue),
    .probe_x   (probe_x),
    .probe_y   (probe_y),
    .locked    (locked),
    .line_err  (line_err),
    .frame_err (frame_err),
    .frame_done(frame_done),
    .cell_valid(cell_valid),
    .cell_color(cell_color)
  );

  always #5 pixel_clk = ~pixel_clk;

  always @(negedge pixel_clk) begin
    if (line_err)  n_le <= n_le + 1;
    if (frame_err) n_fe <= n_fe + 1;
    if (cell_valid) n_cv <= n_cv + 1;
    if (frame_done) begin
      n_fd       <= n_fd + 1;
      last_valid <= cell_valid;
      last_color <= cell_color;
    end
    if (line_err || frame_err) begin
      err_lock_now  <= locked;
      err_lock_prev <= prev_locked;
    end
    prev_locked <= locked;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Colour at stream column c of line l: column X appears HA+PD clocks into
  // the line and row Y appears VA lines into the frame.
  function automatic logic [7:0] pix(input int c, input int l);
    int x, y;
    x = c - (HA + PD);
    y = l - VA;
    if (x >= 32 && x < 40 && y >= 16 && y < 24) return 8'b000_111_00;
    return 8'h00;
  endfunction

  // One frame. vsync is low for vs_low lines. Line long_line carries one
  // extra clock. At column 50 of line rst_line, reset is pulsed.
  task automatic drive_frame(input int vs_low, input int long_line, input int rst_line);
    for (int l = 0; l < VT; l++) begin
      int len;
      len = (l == long_line) ? HT + 1 : HT;
      for (int c = 0; c < len; c++) begin
        @(negedge pixel_clk);
        hsync = (c >= HS);
        vsync = (l >= vs_low);
        {vgared, vgagreen, vgablue} = pix(c, l);
        if (l == rst_line && c == 50) begin
          check("rst_pre_locked", locked, 1);
          reset_n = 1'b0;
          #1;
          check("rst_locked", locked, 0);
          check("rst_color", cell_color, 0);
          check("rst_valid", cell_valid, 0);
          check("rst_done", frame_done, 0);
          check("rst_errs", {line_err, frame_err}, 0);
          #3;
          reset_n = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic snap();
    s_le = n_le;
    s_fe = n_fe;
    s_fd = n_fd;
  endtask

  initial begin
    reset_n = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    {vgared, vgagreen, vgablue} = 8'h00;
    probe_x = 7'd4;
    probe_y = 7'd2;
    repeat (3) @(negedge pixel_clk);
    check("reset_locked", locked, 0);
    check("reset_line_err", line_err, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_cell_valid", cell_valid, 0);
    check("reset_cell_color", cell_color, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge pixel_clk);

    // Nominal frames; lock arrives at the third frame start.
    snap();
    drive_frame(VS, -1, -1);
    drive_frame(VS, -1, -1);
    check("f1_locked", locked, 0);
    drive_frame(VS, -1, -1);
    check("f2_locked", locked, 1);
    check("f2_no_valid", last_valid, 0);
    probe_x = 7'd80;
    drive_frame(VS, -1, -1);
    check("f3_valid", last_valid, 1);
    check("f3_green", last_color, 3'b010);
    probe_x = 7'd5;
    drive_frame(VS, -1, -1);
    check("f4_oor_valid", last_valid, 0);
    check("f4_oor_hold", last_color, 3'b010);
    check("nominal_line_err", n_le - s_le, 0);
    check("nominal_frame_err", n_fe - s_fe, 0);
    check("nominal_frame_done", n_fd - s_fd, 5);

    // One 101-clock line while locked.
    probe_x = 7'd4;
    snap();
    drive_frame(VS, 10, -1);
    check("f5_valid", last_valid, 1);
    check("f5_black", last_color, 3'b000);
    check("long_line_err", n_le - s_le, 1);
    check("long_frame_err", n_fe - s_fe, 0);
    check("long_lock_prev", err_lock_prev, 1);
    check("long_lock_drop", err_lock_now, 0);
    snap();
    drive_frame(VS, -1, -1);
    check("f6_locked", locked, 0);
    check("f6_no_valid", last_valid, 0);
    drive_frame(VS, -1, -1);
    check("f7_locked", locked, 0);
    drive_frame(VS, -1, -1);
    check("f8_relocked", locked, 1);
    check("relock_errs", (n_le - s_le) + (n_fe - s_fe), 0);

    // Reset pulse mid-line while locked, then recovery.
    snap();
    drive_frame(VS, -1, 20);
    check("f9_valid", last_valid, 1);
    check("f9_green", last_color, 3'b010);
    drive_frame(VS, -1, -1);
    drive_frame(VS, -1, -1);
    check("f11_locked", locked, 0);
    check("post_rst_line_err", n_le - s_le, 0);
    check("post_rst_frame_err", n_fe - s_fe, 0);

    // vsync held low for three lines in the frame that regains lock.
    snap();
    drive_frame(3, -1, -1);
    check("vs3_frame_err", n_fe - s_fe, 1);
    check("vs3_line_err", n_le - s_le, 0);
    check("vs3_lock_prev", err_lock_prev, 1);
    check("vs3_lock_drop", err_lock_now, 0);
    check("vs3_locked", locked, 0);
    snap();
    drive_frame(VS, -1, -1);
    check("f13_done", n_fd - s_fd, 1);
    check("f13_no_valid", last_valid, 0);
    check("total_frame_done", n_fd, 14);
    check("total_cell_valid", n_cv, 3);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
